gcd_job_sequencer: RTL and testbench
====================================

Name: gcd_job_sequencer

Overview:
Initiator side of the GCD engine start/done interface. Buffers operand pairs in a small queue and launches each pair on the engine. Holds eng_start for the whole computation, captures the result on eng_done, and returns it on a valid/ready output port. Handles zero operands locally and guards against a hung engine with a timeout.

Parameters:
WIDTH, 8, operand/result width in bits
DEPTH, 4, operand queue entries (power of 2, >=2)
TIMEOUT, 1023, max cycles in RUN before abort (>=8); counter width = clog2(TIMEOUT+1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  operand pair offered
in_ready  out  1  queue can accept (= !full)
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
eng_start  out  1  engine run request; held high for the whole job
eng_a  out  WIDTH  operand A to engine; stable while eng_start=1
eng_b  out  WIDTH  operand B to engine; stable while eng_start=1
eng_done  in  1  engine completion, one-cycle pulse
eng_result  in  WIDTH  engine result, valid when eng_done=1
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_result  out  WIDTH  GCD result
out_error  out  1  1 = timeout or both operands zero
busy  out  1  FSM not in IDLE, or queue not empty

Behaviour:
- Reset (async): FSM=IDLE; queue empty; all outputs 0 except in_ready=1; timeout counter 0. Reset mid-job drops eng_start immediately and discards the queue and in-flight job.
- All outputs except in_ready and busy are registered.
- Queue: push on in_valid&&in_ready. Pop only on IDLE exit. Push and pop in the same cycle are both performed. Read/write pointers wrap modulo DEPTH. Full = DEPTH entries. in_a/in_b are ignored when in_ready=0.
- FSM states:
  - IDLE: if queue non-empty, pop head into opA/opB. Then:
    - opA!=0 and opB!=0 -> RUN; eng_a/eng_b loaded; eng_start=1 from the next cycle.
    - exactly one operand zero -> result = opA|opB, error=0 -> RESP. eng_start is never asserted.
    - both zero -> result=0, error=1 -> RESP.
  - RUN: eng_start=1; counter increments every cycle.
    - eng_done=1 -> capture eng_result, error=0 -> COOL.
    - counter==TIMEOUT without eng_done -> result=0, error=1 -> COOL.
    - If eng_done arrives on the same cycle as the timeout, done wins (error=0).
  - COOL: eng_start=0 for exactly one cycle so the engine returns to its idle state; counter cleared -> RESP.
  - RESP: out_valid=1 with out_result/out_error stable until out_ready=1. On accept: out_valid=0 -> IDLE.
- eng_done outside RUN is ignored.
- eng_a/eng_b hold their last value outside RUN.
- Latency: head popped at edge t -> eng_start high from t+1. eng_done sampled at edge d -> out_valid high from d+2 (one COOL cycle). Zero-operand path: out_valid from t+1.
- Throughput: one job in flight. A new job launches at the earliest on the cycle after RESP accept.
- Arithmetic: no arithmetic beyond OR and counter compare. Counter saturates, never wraps.

Test Plan:
- Push (12,18); engine model returns 6 five cycles after eng_start -> eng_a=12, eng_b=18 stable while eng_start=1; eng_start low one cycle after done; out_result=6, out_error=0.
- Push (0,9), then (7,0) -> out_result=9, then 7; out_error=0; eng_start never asserted.
- Push (0,0) -> out_result=0, out_error=1; no engine activity.
- Engine model never asserts done, TIMEOUT=16 -> eng_start high exactly 16 cycles, then low; out_result=0, out_error=1.
- out_ready=0, push DEPTH+2 pairs back-to-back -> in_ready=0 after DEPTH+1 accepted (DEPTH queued + 1 in flight). Release out_ready -> all results returned in push order, none lost or duplicated.
- Assert rst while in RUN with 2 queued jobs -> eng_start=0 and out_valid=0 asynchronously. After release: busy=0, in_ready=1, no stale result produced.

Source files
------------

// File: rtl/gcd_job_sequencer.sv
// gcd_job_sequencer
// Initiator side of the GCD engine start/done handshake. Operand pairs are
// buffered in a small FIFO and launched one at a time on the engine. Results,
// including locally resolved zero-operand jobs and engine timeouts, are
// returned on a valid/ready port in push order.
module gcd_job_sequencer #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             eng_start,
    output logic [WIDTH-1:0] eng_a,
    output logic [WIDTH-1:0] eng_b,
    input  logic             eng_done,
    input  logic [WIDTH-1:0] eng_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_error,
    output logic             busy
);

    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int CW   = $clog2(TIMEOUT + 1);

    localparam logic [CNTW-1:0] DEPTH_C   = CNTW'(DEPTH);
    localparam logic [CW-1:0]   TIMEOUT_C = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        COOL = 2'd2,
        RESP = 2'd3
    } state_t;

    // Operand FIFO storage and bookkeeping
    logic [WIDTH-1:0] memA_q [DEPTH];
    logic [WIDTH-1:0] memB_q [DEPTH];
    logic [PW-1:0]    wrPtr_q;
    logic [PW-1:0]    rdPtr_q;
    logic [CNTW-1:0]  count_q;

    // FSM state and registered outputs
    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             engStart_q;
    logic [WIDTH-1:0] engA_q;
    logic [WIDTH-1:0] engB_q;
    logic             outValid_q;
    logic [WIDTH-1:0] outResult_q;
    logic             outError_q;

    logic             full;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] headA;
    logic [WIDTH-1:0] headB;
    logic             timeoutHit;

    assign full     = (count_q == DEPTH_C);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = (state_q == IDLE) && (count_q != '0);
    assign headA    = memA_q[rdPtr_q];
    assign headB    = memB_q[rdPtr_q];
    assign busy     = (state_q != IDLE) || (count_q != '0);

    assign eng_start  = engStart_q;
    assign eng_a      = engA_q;
    assign eng_b      = engB_q;
    assign out_valid  = outValid_q;
    assign out_result = outResult_q;
    assign out_error  = outError_q;

    // Saturating run-cycle counter; a job times out when the count reaches TIMEOUT
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != TIMEOUT_C) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign timeoutHit = (cnt_d == TIMEOUT_C);

    // Operand storage is written on every accepted push; no reset needed since
    // the occupancy count decides which entries are meaningful
    always_ff @(posedge clk) begin
        if (push) begin
            memA_q[wrPtr_q] <= in_a;
            memB_q[wrPtr_q] <= in_b;
        end
    end

    // FIFO pointers and occupancy; push and pop in one cycle leave the count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + PW'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNTW'(1);
                2'b01:   count_q <= count_q - CNTW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Job sequencing FSM: launch, wait for done or timeout, cool down, respond
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            engStart_q  <= 1'b0;
            engA_q      <= '0;
            engB_q      <= '0;
            outValid_q  <= 1'b0;
            outResult_q <= '0;
            outError_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        if ((headA != '0) && (headB != '0)) begin
                            engA_q     <= headA;
                            engB_q     <= headB;
                            engStart_q <= 1'b1;
                            cnt_q      <= '0;
                            state_q    <= RUN;
                        end else if ((headA == '0) && (headB == '0)) begin
                            outResult_q <= '0;
                            outError_q  <= 1'b1;
                            outValid_q  <= 1'b1;
                            state_q     <= RESP;
                        end else begin
                            outResult_q <= headA | headB;
                            outError_q  <= 1'b0;
                            outValid_q  <= 1'b1;
                            state_q     <= RESP;
                        end
                    end
                end
                RUN: begin
                    cnt_q <= cnt_d;
                    if (eng_done) begin
                        outResult_q <= eng_result;
                        outError_q  <= 1'b0;
                        engStart_q  <= 1'b0;
                        state_q     <= COOL;
                    end else if (timeoutHit) begin
                        outResult_q <= '0;
                        outError_q  <= 1'b1;
                        engStart_q  <= 1'b0;
                        state_q     <= COOL;
                    end
                end
                COOL: begin
                    cnt_q      <= '0;
                    outValid_q <= 1'b1;
                    state_q    <= RESP;
                end
                RESP: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Testbench for gcd_job_sequencer: engine model, job-level reference queue,
// per-cycle output comparison and directed scenarios with literal results.
module tb_gcd_job_sequencer;

    localparam int WIDTH   = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             eng_start;
    logic [WIDTH-1:0] eng_a;
    logic [WIDTH-1:0] eng_b;
    logic             eng_done;
    logic [WIDTH-1:0] eng_result;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_error;
    logic             busy;

    gcd_job_sequencer #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .eng_start  (eng_start),
        .eng_a      (eng_a),
        .eng_b      (eng_b),
        .eng_done   (eng_done),
        .eng_result (eng_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_error  (out_error),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] res;
        logic             err;
    } job_t;

    job_t expQ[$];
    int   resultLog[$];
    int   errLog[$];
    int   testsRun    = 0;
    int   testsFailed = 0;
    bit   hang        = 1'b0;
    int   engCnt      = 0;
    int   runLen      = 0;
    int   lastRunLen  = 0;
    int   launches    = 0;
    logic prevStart   = 1'b0;
    logic prevHold    = 1'b0;
    logic [WIDTH-1:0] prevRes;
    logic             prevErr;

    function automatic int gcdOf(int a, int b);
        int t;
        while (b != 0) begin
            t = b;
            b = a % b;
            a = t;
        end
        return a;
    endfunction

    // Expected outcome of one job, decided from the operands and the engine mode
    function automatic job_t makeJob(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
        job_t j;
        j.a = a;
        j.b = b;
        if (a == 0 && b == 0) begin
            j.res = '0;
            j.err = 1'b1;
        end else if (a == 0 || b == 0) begin
            j.res = a | b;
            j.err = 1'b0;
        end else if (hang) begin
            j.res = '0;
            j.err = 1'b1;
        end else begin
            j.res = WIDTH'(gcdOf(int'(a), int'(b)));
            j.err = 1'b0;
        end
        return j;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s", name);
    endtask

    // Offer one pair for a single cycle; called just after a rising edge
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, output bit accepted);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        accepted = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (accepted) expQ.push_back(makeJob(a, b));
    endtask

    task automatic waitResults(input int target, input int budget);
        int n = 0;
        while (resultLog.size() < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (resultLog.size() < target) failNow("result wait timed out");
        @(posedge clk);
        #1;
    endtask

    // Engine model: answers with the gcd five cycles into a run unless hung
    always @(negedge clk) begin
        if (eng_start) begin
            engCnt++;
            if (engCnt == 5 && !hang) begin
                eng_done   = 1'b1;
                eng_result = WIDTH'(gcdOf(int'(eng_a), int'(eng_b)));
            end else begin
                eng_done = 1'b0;
            end
        end else begin
            engCnt   = 0;
            eng_done = 1'b0;
        end
    end

    // Measures each eng_start pulse length and counts engine launches
    always @(negedge clk) begin
        if (eng_start) begin
            runLen++;
            if (!prevStart) launches++;
        end else if (runLen > 0) begin
            lastRunLen = runLen;
            runLen     = 0;
        end
        prevStart = eng_start;
    end

    // Per-cycle comparison of engine operands and returned results against the job queue
    always @(negedge clk) begin
        if (rst) begin
            prevHold = 1'b0;
        end else begin
            if (eng_start) begin
                if (expQ.size() == 0) begin
                    failNow("eng_start with no pending job");
                end else begin
                    checkOutput("eng_a", eng_a, expQ[0].a);
                    checkOutput("eng_b", eng_b, expQ[0].b);
                end
            end
            if (out_valid) begin
                if (prevHold) begin
                    checkOutput("held out_result", out_result, prevRes);
                    checkOutput("held out_error", out_error, prevErr);
                end
                if (expQ.size() == 0) begin
                    failNow("unexpected out_valid");
                end else if (out_ready) begin
                    checkOutput("out_result", out_result, expQ[0].res);
                    checkOutput("out_error", out_error, expQ[0].err);
                    resultLog.push_back(int'(out_result));
                    errLog.push_back(int'(out_error));
                    void'(expQ.pop_front());
                end
                prevHold = !out_ready;
                prevRes  = out_result;
                prevErr  = out_error;
            end else begin
                prevHold = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit acc;
        int base;
        int accCount;
        int launchBase;
        eng_done   = 1'b0;
        eng_result = '0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        out_ready  = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset eng_start", eng_start, 0);
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset out_result", out_result, 0);
        checkOutput("reset out_error", out_error, 0);
        checkOutput("reset eng_a", eng_a, 0);
        checkOutput("reset in_ready", in_ready, 1);
        checkOutput("reset busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Normal engine job
        launchBase = launches;
        base = resultLog.size();
        applyStimulus(8'd12, 8'd18, acc);
        checkOutput("t1 accepted", acc, 1);
        waitResults(base + 1, 60);
        if (resultLog.size() > base) begin
            checkOutput("t1 result 6", resultLog[base], 6);
            checkOutput("t1 error", errLog[base], 0);
        end
        checkOutput("t1 eng_start length", lastRunLen, 5);
        checkOutput("t1 launches", launches - launchBase, 1);

        // One-zero operands resolved locally
        launchBase = launches;
        base = resultLog.size();
        applyStimulus(8'd0, 8'd9, acc);
        applyStimulus(8'd7, 8'd0, acc);
        waitResults(base + 2, 40);
        if (resultLog.size() > base + 1) begin
            checkOutput("t2 result 9", resultLog[base], 9);
            checkOutput("t2 result 7", resultLog[base + 1], 7);
            checkOutput("t2 error a", errLog[base], 0);
            checkOutput("t2 error b", errLog[base + 1], 0);
        end
        checkOutput("t2 no launches", launches - launchBase, 0);

        // Both operands zero
        launchBase = launches;
        base = resultLog.size();
        applyStimulus(8'd0, 8'd0, acc);
        waitResults(base + 1, 40);
        if (resultLog.size() > base) begin
            checkOutput("t3 result", resultLog[base], 0);
            checkOutput("t3 error", errLog[base], 1);
        end
        checkOutput("t3 no launches", launches - launchBase, 0);

        // Hung engine hits the timeout
        hang = 1'b1;
        launchBase = launches;
        base = resultLog.size();
        applyStimulus(8'd20, 8'd30, acc);
        waitResults(base + 1, 80);
        hang = 1'b0;
        if (resultLog.size() > base) begin
            checkOutput("t4 result", resultLog[base], 0);
            checkOutput("t4 error", errLog[base], 1);
        end
        checkOutput("t4 eng_start length", lastRunLen, TIMEOUT);
        checkOutput("t4 launches", launches - launchBase, 1);

        // Backpressure: DEPTH queued plus one in flight
        out_ready = 1'b0;
        base = resultLog.size();
        accCount = 0;
        applyStimulus(8'd12, 8'd18, acc); accCount += int'(acc);
        applyStimulus(8'd0,  8'd5,  acc); accCount += int'(acc);
        applyStimulus(8'd9,  8'd6,  acc); accCount += int'(acc);
        applyStimulus(8'd0,  8'd0,  acc); accCount += int'(acc);
        applyStimulus(8'd35, 8'd14, acc); accCount += int'(acc);
        applyStimulus(8'd8,  8'd12, acc); accCount += int'(acc);
        checkOutput("t5 accepted count", accCount, DEPTH + 1);
        checkOutput("t5 last rejected", acc, 0);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("t5 in_ready full", in_ready, 0);
        checkOutput("t5 busy", busy, 1);
        checkOutput("t5 nothing returned", resultLog.size() - base, 0);
        out_ready = 1'b1;
        waitResults(base + 5, 300);
        if (resultLog.size() >= base + 5) begin
            checkOutput("t5 r0", resultLog[base],     6);
            checkOutput("t5 r1", resultLog[base + 1], 5);
            checkOutput("t5 r2", resultLog[base + 2], 3);
            checkOutput("t5 r3", resultLog[base + 3], 0);
            checkOutput("t5 r4", resultLog[base + 4], 7);
            checkOutput("t5 e3", errLog[base + 3], 1);
        end
        checkOutput("t5 model drained", expQ.size(), 0);
        checkOutput("t5 no extra results", resultLog.size() - base, 5);

        // Reset while running with two queued jobs
        hang = 1'b1;
        base = resultLog.size();
        accCount = 0;
        applyStimulus(8'd4,  8'd6,  acc); accCount += int'(acc);
        applyStimulus(8'd10, 8'd15, acc); accCount += int'(acc);
        applyStimulus(8'd21, 8'd14, acc); accCount += int'(acc);
        checkOutput("t6 accepted", accCount, 3);
        checkOutput("t6 running", eng_start, 1);
        rst = 1'b1;
        expQ.delete();
        #1;
        checkOutput("t6 async eng_start", eng_start, 0);
        checkOutput("t6 async out_valid", out_valid, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        hang = 1'b0;
        launchBase = launches;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("t6 busy", busy, 0);
        checkOutput("t6 in_ready", in_ready, 1);
        checkOutput("t6 no stale result", resultLog.size() - base, 0);
        checkOutput("t6 no relaunch", launches - launchBase, 0);

        // Recovery after reset
        applyStimulus(8'd3, 8'd9, acc);
        waitResults(base + 1, 60);
        if (resultLog.size() > base) checkOutput("t7 result", resultLog[base], 3);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
